// File: rtl/fpnew_pkg.sv
// fpnew_pkg: the shared FPU types this slice relies on (formats, rounding
// modes, operations, format width helpers) and the divsqrt request bundle
// that is buffered by fpnew_divsqrt_issue_queue.
package fpnew_pkg;

  localparam int unsigned NUM_FP_FORMATS = 5;
  localparam int unsigned FP_FORMAT_BITS = 3;
  localparam int unsigned FP_MAX_WIDTH   = 64;

  typedef logic [0:NUM_FP_FORMATS-1] fmt_logic_t;

  typedef enum logic [FP_FORMAT_BITS-1:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY,
    F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned max_fp_width(input fmt_logic_t cfg);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < NUM_FP_FORMATS; i++) begin
      if (cfg[i] && fp_width(fp_format_e'(i[FP_FORMAT_BITS-1:0])) > res) begin
        res = fp_width(fp_format_e'(i[FP_FORMAT_BITS-1:0]));
      end
    end
    return res;
  endfunction

  // Operands are held at the widest possible format width so the bundle does
  // not depend on the per-instance format configuration; narrower instances
  // zero-extend on write and use the low bits on read.
  typedef struct packed {
    logic [1:0][FP_MAX_WIDTH-1:0]     operands;
    logic [NUM_FP_FORMATS-1:0][1:0]   is_boxed;
    roundmode_e                       rnd_mode;
    operation_e                       op;
    fp_format_e                       dst_fmt;
  } divsqrt_req_t;

endpackage

// File: rtl/fpnew_divsqrt_issue_queue.sv
// fpnew_divsqrt_issue_queue: small FIFO in front of the iterative divide /
// square-root unit. Buffers up to Depth complete op bundles so the dispatcher
// is not stalled for the full iterative latency. in_ready_o is derived only
// from the local occupancy, cutting the ready path from the divsqrt unit.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), async active-high reset
//   operands_i .. aux_i    op bundle offered by the dispatcher
//   in_valid_i/in_ready_o  upstream handshake
//   flush_i                synchronous flush (drops all entries)
//   operands_o .. aux_o    head-entry payload
//   out_valid_o/out_ready_i downstream handshake to the divsqrt unit
//   fill_level_o           current occupancy
//   busy_o                 at least one entry held
module fpnew_divsqrt_issue_queue
  import fpnew_pkg::*;
#(
  parameter fmt_logic_t  FpFmtConfig = '1,
  parameter int unsigned Depth       = 2,
  parameter type         TagType     = logic,
  parameter type         AuxType     = logic,
  localparam int unsigned WIDTH      = max_fp_width(FpFmtConfig),
  localparam int unsigned CntW       = $clog2(Depth + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [1:0][WIDTH-1:0]            operands_i,
  input  logic [NUM_FP_FORMATS-1:0][1:0]   is_boxed_i,
  input  roundmode_e                       rnd_mode_i,
  input  operation_e                       op_i,
  input  fp_format_e                       dst_fmt_i,
  input  TagType                           tag_i,
  input  AuxType                           aux_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic                             flush_i,
  output logic [1:0][WIDTH-1:0]            operands_o,
  output logic [NUM_FP_FORMATS-1:0][1:0]   is_boxed_o,
  output roundmode_e                       rnd_mode_o,
  output operation_e                       op_o,
  output fp_format_e                       dst_fmt_o,
  output TagType                           tag_o,
  output AuxType                           aux_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [CntW-1:0]                  fill_level_o,
  output logic                             busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    divsqrt_req_t req;
    TagType       tag;
    AuxType       aux;
  } entry_t;

  if (Depth < 1 || Depth > 16) begin : g_depth_check
    $error("fpnew_divsqrt_issue_queue: Depth must be in 1..16");
  end

  entry_t            mem [Depth];
  entry_t            wr_entry;
  entry_t            head;
  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              push;
  logic              pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready_o   = (cnt_q != CntW'(Depth));
  assign out_valid_o  = (cnt_q != '0);
  assign busy_o       = (cnt_q != '0);
  assign fill_level_o = cnt_q;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  always_comb begin
    wr_entry              = '0;
    for (int i = 0; i < 2; i++) begin
      wr_entry.req.operands[i] = FP_MAX_WIDTH'(operands_i[i]);
    end
    wr_entry.req.is_boxed = is_boxed_i;
    wr_entry.req.rnd_mode = rnd_mode_i;
    wr_entry.req.op       = op_i;
    wr_entry.req.dst_fmt  = dst_fmt_i;
    wr_entry.tag          = tag_i;
    wr_entry.aux          = aux_i;
  end

  // Flush resets only the bookkeeping; stale payload stays in the array and
  // is never visible because out_valid_o drops with the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wptr_q] <= wr_entry;
        wptr_q      <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head payload comes straight from storage: no bypass from the inputs.
  assign head = mem[rptr_q];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      operands_o[i] = head.req.operands[i][WIDTH-1:0];
    end
  end

  assign is_boxed_o = head.req.is_boxed;
  assign rnd_mode_o = head.req.rnd_mode;
  assign op_o       = head.req.op;
  assign dst_fmt_o  = head.req.dst_fmt;
  assign tag_o      = head.tag;
  assign aux_o      = head.aux;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && cnt_q == CntW'(Depth)))
        else $error("issue queue: push while full");
      assert (!(pop && cnt_q == '0))
        else $error("issue queue: pop while empty");
      assert (cnt_q <= CntW'(Depth))
        else $error("issue queue: count exceeds Depth");
    end
  end

endmodule

// File: doc/fpnew_divsqrt_issue_queue.md
Name: fpnew_divsqrt_issue_queue

Overview:
- Small FIFO placed directly upstream of the multi-cycle divide/square-root unit, on the path from the operation-group dispatcher into the divsqrt unit's input handshake.
- Accepts complete op bundles: operands, boxing flags, rounding mode, op, destination format, tag, aux.
- Buffers up to Depth ops so upstream is not stalled for the whole iterative latency.
- Cuts the combinational in_ready path: in_ready_o depends only on local state, never on out_ready_i.

Parameters:
- FpFmtConfig, '1, enabled FP formats; sets WIDTH = fpnew_pkg::max_fp_width(FpFmtConfig).
- Depth, 2, number of entries; legal range 1..16, need not be a power of two.
- TagType, logic, tag payload type.
- AuxType, logic, aux payload type.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- operands_i  in  2xWIDTH  source operands.
- is_boxed_i  in  NUM_FP_FORMATSx2  NaN-boxing flags per format and operand.
- rnd_mode_i  in  roundmode_e  rounding mode.
- op_i  in  operation_e  DIV or SQRT.
- dst_fmt_i  in  fp_format_e  destination format.
- tag_i  in  TagType  tag.
- aux_i  in  AuxType  aux.
- in_valid_i  in  1  upstream valid.
- in_ready_o  out  1  upstream ready.
- flush_i  in  1  synchronous flush.
- operands_o, is_boxed_o, rnd_mode_o, op_o, dst_fmt_o, tag_o, aux_o  out  (same widths)  head-entry payload.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream (divsqrt) ready.
- fill_level_o  out  $clog2(Depth+1)  current occupancy.
- busy_o  out  1  any valid entry held.

Behaviour:
- State: payload array [Depth], write pointer, read pointer, count register.
- Reset (rst_i high, asynchronous), all values held while rst_i is high:
  - pointers 0, count 0, storage '0; rnd RNE, op FMADD, fmt fp_format_e'(0).
  - out_valid_o 0, busy_o 0, fill_level_o 0, in_ready_o 1, payload outputs show entry 0 (reset values).
- Handshake:
  - push = in_valid_i & in_ready_o & ~flush_i
  - pop = out_valid_o & out_ready_i & ~flush_i
- Ready and valid:
  - in_ready_o = (count != Depth); it never depends on out_ready_i. When full, a pop in a given cycle does not allow a push in that same cycle.
  - out_valid_o = (count != 0).
- Output mux: payload outputs = entry[read pointer], purely from registered state.
- Latency: an item pushed at edge N is visible on out_valid_o after edge N, i.e. 1 cycle. There is no combinational bypass, even when empty.
- Push: write entry[wptr]; wptr = (wptr == Depth-1) ? 0 : wptr+1.
- Pop: rptr advances with the same wrap rule.
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Simultaneous push and pop when count is 1: the head advances to the new entry, out_valid_o stays 1.
- Flush:
  - Has priority over push and pop.
  - At the next edge, pointers and count go to 0; stored payload is not cleared.
  - During a flush cycle, in_ready_o follows its normal rule but push is suppressed.
  - out_valid_o is not gated combinationally by flush_i; the divsqrt unit already gates its own start with flush.
- Stability: while out_valid_o=1 and out_ready_i=0, payload outputs stay stable (head only moves on pop).
- busy_o = (count != 0).
- fill_level_o = count.
- Assertions (simulation only):
  - no push when full
  - no pop when empty
  - count <= Depth
  - Depth >= 1

Decomposition:
- Reuse fpnew_pkg for roundmode_e, operation_e, fp_format_e, max_fp_width and NUM_FP_FORMATS.
- Add to fpnew_pkg a packed struct divsqrt_req_t holding operands, is_boxed, rnd_mode, op and dst_fmt; tag and aux remain separate type parameters.
- No sub-module: pointer and count logic is inline, and the storage is a single array of {divsqrt_req_t, TagType, AuxType}.

Test Plan:
- Reset then idle: rst_i pulse → in_ready_o=1, out_valid_o=0, fill_level_o=0, busy_o=0, and they stay so with no stimulus.
- Fill and drain, Depth=2, out_ready_i=0:
  - push tags 5 then 6 → fill_level_o=2, in_ready_o=0, head tag_o=5.
  - raise out_ready_i → tags 5, 6 appear in order; in_ready_o returns to 1 the cycle after the first pop.
- Streaming, Depth=3, in_valid_i and out_ready_i held high for 20 cycles:
  - tags 0..19 exit in order, 1-cycle latency, fill_level_o steady at 1.
  - pointers wrap correctly past index 2.
- Full with simultaneous pop, Depth=2: in_valid_i=1 with tag 7 while full and popping → tag 7 not accepted that cycle; accepted next cycle; no loss or duplication.
- Flush mid-stream, count=2, flush_i=1 with in_valid_i=1 and out_ready_i=1 → next cycle count=0, out_valid_o=0; the offered op is dropped and nothing is popped.
- Asynchronous reset while holding entries: assert rst_i between edges with count=2 → out_valid_o=0 and fill_level_o=0 immediately, before the next clock edge.
